lookup_input_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges four AXI4-Stream receive interfaces onto the single stream feeding the router output-port-lookup pipeline, which contains the packet filter stage. Each input has a 16-entry fall-through buffer. Once an input is granted, the arbiter forwards every beat of that input's packet without interleaving. It also keeps a forwarded-packet counter for the register block.

---
 rtl/lookup_arb_pkg.sv | 17 +
 rtl/fallthrough_small_fifo.sv | 34 +++
 rtl/lookup_input_arbiter.sv | 96 +++++++++
 tb/tb_lookup_input_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lookup_arb_pkg.sv
// lookup_arb_pkg: shared widths, FSM encoding and round-robin pick for the lookup input arbiter
package lookup_arb_pkg;
  localparam int NUM_INPUTS = 4;
  localparam int DATA_W = 256;
  localparam int USER_W = 128;
  localparam int DEPTH_BITS = 4;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  function automatic logic [1:0] rr_pick(input logic [3:0] ne, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    // walk from the farthest offset back so the closest non-empty input wins
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (ne[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: first-word fall-through FIFO; nearly_full asserts with one free entry left
module fallthrough_small_fifo #(
  parameter int WIDTH = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam logic [MAX_DEPTH_BITS:0] NEAR = {1'b0, {MAX_DEPTH_BITS{1'b1}}};
  logic [WIDTH-1:0] mem [2**MAX_DEPTH_BITS];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0] depth;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth <= '0;
    end else begin
      wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(wr_en);
      rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(rd_en);
      depth <= depth + (MAX_DEPTH_BITS+1)'(wr_en) - (MAX_DEPTH_BITS+1)'(rd_en);
    end
  assign dout = mem[rd_ptr];
  assign empty = depth == '0;
  assign nearly_full = depth >= NEAR;
endmodule

// File: rtl/lookup_input_arbiter.sv
// lookup_input_arbiter: packet-granular round-robin merge of four AXI4-Stream inputs
// onto the output-port-lookup stream, with a forwarded-packet counter.
module lookup_input_arbiter
  import lookup_arb_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = DATA_W,
  parameter int C_AXIS_TUSER_WIDTH = USER_W,
  parameter int FIFO_DEPTH_BITS = DEPTH_BITS
) (
  input  logic                            AXI_ACLK,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S0_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S0_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S0_AXIS_TUSER,
  input  logic                            S0_AXIS_TVALID,
  input  logic                            S0_AXIS_TLAST,
  output logic                            S0_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S1_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S1_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S1_AXIS_TUSER,
  input  logic                            S1_AXIS_TVALID,
  input  logic                            S1_AXIS_TLAST,
  output logic                            S1_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S2_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S2_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S2_AXIS_TUSER,
  input  logic                            S2_AXIS_TVALID,
  input  logic                            S2_AXIS_TLAST,
  output logic                            S2_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S3_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S3_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S3_AXIS_TUSER,
  input  logic                            S3_AXIS_TVALID,
  input  logic                            S3_AXIS_TLAST,
  output logic                            S3_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  input  logic                            stats_clear,
  output logic [31:0]                     pkt_count,
  output logic [1:0]                      cur_grant
);
  localparam int FW = C_AXIS_DATA_WIDTH + C_AXIS_TUSER_WIDTH + C_AXIS_DATA_WIDTH/8 + 1;
  logic [FW-1:0] din [NUM_INPUTS];
  logic [FW-1:0] head [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] valid, nf, empty, rd;
  logic head_last, accept_last;
  state_t state;
  logic [1:0] grant, next_ptr;
  assign din[0] = {S0_AXIS_TLAST, S0_AXIS_TSTRB, S0_AXIS_TUSER, S0_AXIS_TDATA};
  assign din[1] = {S1_AXIS_TLAST, S1_AXIS_TSTRB, S1_AXIS_TUSER, S1_AXIS_TDATA};
  assign din[2] = {S2_AXIS_TLAST, S2_AXIS_TSTRB, S2_AXIS_TUSER, S2_AXIS_TDATA};
  assign din[3] = {S3_AXIS_TLAST, S3_AXIS_TSTRB, S3_AXIS_TUSER, S3_AXIS_TDATA};
  assign valid = {S3_AXIS_TVALID, S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};
  assign {S3_AXIS_TREADY, S2_AXIS_TREADY, S1_AXIS_TREADY, S0_AXIS_TREADY} = ~nf;
  always_comb
    for (int k = 0; k < NUM_INPUTS; k++)
      rd[k] = state == SEND && grant == 2'(k) && !empty[k] && M_AXIS_TREADY;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    fallthrough_small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
      .clk(AXI_ACLK),
      .reset(reset),
      .din(din[i]),
      .wr_en(valid[i] & ~nf[i]),
      .rd_en(rd[i]),
      .dout(head[i]),
      .nearly_full(nf[i]),
      .empty(empty[i])
    );
  end
  // valid comes only from registered state and buffer occupancy, never from TREADY
  assign M_AXIS_TVALID = state == SEND && !empty[grant];
  assign {head_last, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TDATA} = head[grant];
  assign M_AXIS_TLAST = M_AXIS_TVALID & head_last;
  assign accept_last = M_AXIS_TLAST & M_AXIS_TREADY;
  assign cur_grant = grant;
  always_ff @(posedge AXI_ACLK)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      next_ptr <= '0;
      pkt_count <= '0;
    end else begin
      if (state == IDLE && |(~empty)) begin
        grant <= rr_pick(~empty, next_ptr);
        state <= SEND;
      end else if (state == SEND && accept_last) begin
        state <= IDLE;
        next_ptr <= grant + 2'd1;
      end
      pkt_count <= stats_clear ? '0 : pkt_count + 32'(accept_last);
    end
endmodule

// File: tb/tb_lookup_input_arbiter.sv
// tb_lookup_input_arbiter: randomized and directed checks of the lookup input arbiter
// against per-input scoreboard queues and packet-level expectations.
module tb_lookup_input_arbiter;
  typedef struct packed {
    logic last;
    logic [31:0] strb;
    logic [127:0] user;
    logic [255:0] data;
  } beat_t;

  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  logic [255:0] s_data [4];
  logic [31:0] s_strb [4];
  logic [127:0] s_user [4];
  logic s_valid [4];
  logic s_last [4];
  wire [3:0] s_ready;
  wire [255:0] m_data;
  wire [31:0] m_strb;
  wire [127:0] m_user;
  wire m_valid, m_last;
  logic m_ready;
  logic stats_clear = 0;
  wire [31:0] pkt_count;
  wire [1:0] cur_grant;

  lookup_input_arbiter dut (
    .AXI_ACLK(clk), .reset(reset),
    .S0_AXIS_TDATA(s_data[0]), .S0_AXIS_TSTRB(s_strb[0]), .S0_AXIS_TUSER(s_user[0]),
    .S0_AXIS_TVALID(s_valid[0]), .S0_AXIS_TLAST(s_last[0]), .S0_AXIS_TREADY(s_ready[0]),
    .S1_AXIS_TDATA(s_data[1]), .S1_AXIS_TSTRB(s_strb[1]), .S1_AXIS_TUSER(s_user[1]),
    .S1_AXIS_TVALID(s_valid[1]), .S1_AXIS_TLAST(s_last[1]), .S1_AXIS_TREADY(s_ready[1]),
    .S2_AXIS_TDATA(s_data[2]), .S2_AXIS_TSTRB(s_strb[2]), .S2_AXIS_TUSER(s_user[2]),
    .S2_AXIS_TVALID(s_valid[2]), .S2_AXIS_TLAST(s_last[2]), .S2_AXIS_TREADY(s_ready[2]),
    .S3_AXIS_TDATA(s_data[3]), .S3_AXIS_TSTRB(s_strb[3]), .S3_AXIS_TUSER(s_user[3]),
    .S3_AXIS_TVALID(s_valid[3]), .S3_AXIS_TLAST(s_last[3]), .S3_AXIS_TREADY(s_ready[3]),
    .M_AXIS_TDATA(m_data), .M_AXIS_TSTRB(m_strb), .M_AXIS_TUSER(m_user),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_ready),
    .stats_clear(stats_clear), .pkt_count(pkt_count), .cur_grant(cur_grant)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  beat_t exp_q [4][$];
  int grant_log [$];
  int pkt_start [$];
  int pkt_end [$];
  int model_pkts = 0;
  int n_beats = 0;
  int acc_cnt [4];
  int wr0_cyc [4];
  int busy = 0;
  bit in_pkt = 0;
  int cur_src = 0;
  bit abort = 0;
  bit rand_rdy = 0;
  bit hold_rdy = 1;
  int pkt_id = 0;

  task automatic chk(input string tag, input logic [447:0] got, input logic [447:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : hold_rdy;
    end
  end

  // scoreboard: every accepted output beat must be the oldest unsent beat of its source
  always @(negedge clk) begin
    beat_t got;
    int src;
    if (!reset && m_valid && m_ready) begin
      got = {m_last, m_strb, m_user, m_data};
      src = int'(m_data[255:254]);
      n_beats++;
      chk("cur_grant", 448'(cur_grant), 448'(src));
      if (in_pkt) chk("no_interleave", 448'(src), 448'(cur_src));
      else begin
        in_pkt = 1;
        cur_src = src;
        pkt_start.push_back(cyc);
      end
      if (exp_q[src].size() == 0) chk("unexpected_beat", 448'(src), 448'(4));
      else chk("beat", 448'(got), 448'(exp_q[src].pop_front()));
      if (m_last) begin
        in_pkt = 0;
        grant_log.push_back(src);
        pkt_end.push_back(cyc);
        model_pkts++;
      end
    end
  end

  task automatic send_pkt(input int p, input int len, input int gap_max);
    beat_t bt;
    int w;
    int id;
    id = pkt_id++;
    for (int b = 0; b < len; b++) begin
      if (abort) return;
      for (int k = 0; k < 8; k++) bt.data[k*32 +: 32] = $urandom;
      bt.data[255:254] = 2'(p);
      bt.data[253:224] = 30'(id * 64 + b);
      for (int k = 0; k < 4; k++) bt.user[k*32 +: 32] = $urandom;
      bt.strb = $urandom;
      bt.last = b == len - 1;
      {s_last[p], s_strb[p], s_user[p], s_data[p]} = bt;
      s_valid[p] = 1;
      w = 0;
      @(negedge clk);
      while (!s_ready[p] && !abort && w < 3000) begin
        w++;
        @(negedge clk);
      end
      if (w >= 3000) begin
        chk("tready_timeout", 448'(w), 448'(0));
        s_valid[p] = 0;
        return;
      end
      if (s_ready[p] && !abort) begin
        if (b == 0) wr0_cyc[p] = cyc;
        exp_q[p].push_back(bt);
        acc_cnt[p]++;
      end
      @(posedge clk);
      #1;
      s_valid[p] = 0;
      w = $urandom_range(0, gap_max);
      repeat (w) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic bit drained();
    drained = busy == 0 && !in_pkt;
    for (int p = 0; p < 4; p++) if (exp_q[p].size() != 0) drained = 0;
  endfunction

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (drained()) break;
    end
    chk(tag, 448'(drained()), 448'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    abort = 1;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 448'(m_valid), 448'(0));
    chk("rst_m_last", 448'(m_last), 448'(0));
    chk("rst_pkt_count", 448'(pkt_count), 448'(0));
    chk("rst_cur_grant", 448'(cur_grant), 448'(0));
    @(posedge clk);
    #1;
    reset = 0;
    abort = 0;
    for (int p = 0; p < 4; p++) begin
      exp_q[p].delete();
      acc_cnt[p] = 0;
    end
    in_pkt = 0;
    grant_log.delete();
    pkt_start.delete();
    pkt_end.delete();
    model_pkts = 0;
    n_beats = 0;
    @(negedge clk);
    chk("post_rst_s_ready", 448'(s_ready), 448'(4'hf));
    chk("post_rst_m_valid", 448'(m_valid), 448'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      s_valid[p] = 0;
      s_last[p] = 0;
      s_data[p] = '0;
      s_strb[p] = '0;
      s_user[p] = '0;
    end
    do_reset();

    // single 3-beat packet: first beat two cycles after the first write, back to back
    send_pkt(0, 3, 0);
    wait_idle("t1_drain");
    chk("t1_latency", 448'(pkt_start[0] - wr0_cyc[0]), 448'(2));
    chk("t1_burst", 448'(pkt_end[0] - pkt_start[0]), 448'(2));
    chk("t1_count", 448'(pkt_count), 448'(1));

    // four simultaneous 2-beat packets drain in order 0..3 with one bubble between
    do_reset();
    fork
      send_pkt(0, 2, 0);
      send_pkt(1, 2, 0);
      send_pkt(2, 2, 0);
      send_pkt(3, 2, 0);
    join
    wait_idle("t2_drain");
    chk("t2_npkts", 448'(grant_log.size()), 448'(4));
    for (int k = 0; k < 4; k++) chk("t2_order", 448'(grant_log[k]), 448'(k));
    for (int k = 0; k < 3; k++) chk("t2_bubble", 448'(pkt_start[k+1] - pkt_end[k]), 448'(2));
    chk("t2_count", 448'(pkt_count), 448'(4));

    // input 2 streams back to back while input 3 waits: 3 must get the second turn
    do_reset();
    fork
      begin
        send_pkt(2, 3, 0);
        send_pkt(2, 3, 0);
      end
      begin
        @(posedge clk);
        #1;
        send_pkt(3, 2, 0);
      end
    join
    wait_idle("t3_drain");
    chk("t3_npkts", 448'(grant_log.size()), 448'(3));
    chk("t3_g0", 448'(grant_log[0]), 448'(2));
    chk("t3_g1", 448'(grant_log[1]), 448'(3));
    chk("t3_g2", 448'(grant_log[2]), 448'(2));

    // backpressure: 15 beats buffer, then TREADY on S1 drops
    do_reset();
    hold_rdy = 0;
    @(posedge clk);
    #2;
    fork
      begin
        busy++;
        send_pkt(1, 20, 0);
        busy--;
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    chk("t4_buffered", 448'(acc_cnt[1]), 448'(15));
    chk("t4_s1_ready", 448'(s_ready[1]), 448'(0));
    chk("t4_no_out", 448'(n_beats), 448'(0));
    hold_rdy = 1;
    wait_idle("t4_drain");
    chk("t4_beats", 448'(n_beats), 448'(20));
    chk("t4_count", 448'(pkt_count), 448'(1));

    // stats_clear coinciding with a TLAST acceptance wins over the increment
    do_reset();
    send_pkt(0, 2, 0);
    wait_idle("t5_drain_a");
    chk("t5_count_pre", 448'(pkt_count), 448'(1));
    fork
      begin
        busy++;
        send_pkt(0, 2, 0);
        busy--;
      end
    join_none
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (m_valid && m_ready && m_last) break;
      end
      chk("t5_last_seen", 448'(k < 100), 448'(1));
    end
    stats_clear = 1;
    @(posedge clk);
    #1;
    stats_clear = 0;
    model_pkts = 0;
    chk("t5_cleared", 448'(pkt_count), 448'(0));
    wait_idle("t5_drain_b");
    send_pkt(2, 1, 0);
    wait_idle("t5_drain_c");
    chk("t5_count_post", 448'(pkt_count), 448'(1));

    // reset mid-packet discards the packet; a fresh one then forwards normally
    do_reset();
    fork
      begin
        busy++;
        send_pkt(0, 8, 0);
        busy--;
      end
    join_none
    begin
      int k;
      for (k = 0; k < 100 && n_beats < 2; k++) @(negedge clk);
      chk("t6_started", 448'(n_beats >= 2), 448'(1));
    end
    do_reset();
    send_pkt(0, 3, 0);
    wait_idle("t6_drain");
    chk("t6_count", 448'(pkt_count), 448'(1));
    chk("t6_model", 448'(model_pkts), 448'(1));

    // randomized traffic on all inputs with random downstream stalls
    do_reset();
    rand_rdy = 1;
    for (int p = 0; p < 4; p++) begin
      fork
        automatic int q = p;
        begin
          busy++;
          for (int n = 0; n < 6; n++) send_pkt(q, $urandom_range(1, 6), 3);
          busy--;
        end
      join_none
    end
    @(posedge clk);
    #1;
    wait_idle("t7_drain");
    rand_rdy = 0;
    chk("t7_model_pkts", 448'(model_pkts), 448'(24));
    chk("t7_count", 448'(pkt_count), 448'(model_pkts));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
